// File: rtl/arbiter4_rr_if.sv
// Requester/arbiter handshake bundle for arbiter4_rr.
// master: the requesting side (drives en/req/done, observes the grant).
// slave:  the arbiter (consumes en/req/done, drives the grant outputs).
interface arbiter4_rr_if;
    logic       en;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    modport master (
        output en, req, done,
        input  gnt, gnt_id, gnt_valid, timeout
    );

    modport slave (
        input  en, req, done,
        output gnt, gnt_id, gnt_valid, timeout
    );
endinterface

// File: rtl/arbiter4_rr.sv
// 4-way arbiter with hold timer and registered one-hot/encoded grant.
// Macro ARB_ROUND_ROBIN_EN: defined = round-robin selection from a rotating
// pointer; undefined = fixed priority, highest request index wins.
// Every grant is followed by one mandatory idle cycle; a grant is
// force-released after HOLD_MAX cycles, flagged by a one-cycle timeout.
module arbiter4_rr #(
    parameter int HOLD_MAX = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    arbiter4_rr_if.slave  bus
);

    typedef enum logic {IDLE, GRANT} state_t;

    // Last tenure count value before the timer forces a release.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

    state_t     state;
    logic [7:0] hold_cnt;
    logic [3:0] gnt_q;
    logic [1:0] gnt_id_q;
    logic       gnt_valid_q;
    logic       timeout_q;

    logic [1:0] win_id;
    logic       any_req;
    logic       rel_en, rel_req, rel_done, rel_hold, rel_other;

    assign any_req = |bus.req;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr;
    logic [1:0] idx;
    logic       found;

    // Round-robin pick: first set request at or after ptr, wrapping mod 4.
    always_comb begin
        win_id = 2'd0;
        idx    = 2'd0;
        found  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && bus.req[idx]) begin
                win_id = idx;
                found  = 1'b1;
            end
        end
    end
`else
    // Fixed priority pick: later (higher) indices overwrite, so 3 beats 0.
    always_comb begin
        win_id = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (bus.req[i]) win_id = 2'(i);
        end
    end
`endif

    // Release causes; the timer only counts as a timeout when it acts alone.
    always_comb begin
        rel_en    = !bus.en;
        rel_req   = !bus.req[gnt_id_q];
        rel_done  = bus.done;
        rel_hold  = (hold_cnt == HOLD_LAST);
        rel_other = rel_en | rel_req | rel_done;
    end

    // Grant FSM: all outputs registered, IDLE always sits one cycle between grants.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= 8'd0;
            gnt_q       <= 4'd0;
            gnt_id_q    <= 2'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr         <= 2'd0;
`endif
        end else begin
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.en && any_req) begin
                        gnt_q       <= 4'b0001 << win_id;
                        gnt_id_q    <= win_id;
                        gnt_valid_q <= 1'b1;
                        hold_cnt    <= 8'd0;
                        state       <= GRANT;
`ifdef ARB_ROUND_ROBIN_EN
                        ptr         <= win_id + 2'd1;
`endif
                    end
                end
                GRANT: begin
                    if (rel_other || rel_hold) begin
                        gnt_q       <= 4'd0;
                        gnt_valid_q <= 1'b0;
                        timeout_q   <= rel_hold && !rel_other;
                        state       <= IDLE;
                    end else if (hold_cnt != 8'hFF) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule
